seq_controller: RTL and testbench
=================================

# seq_controller

Multi-cycle instruction sequencer for the microprocessor core. It replaces the single-cycle fetch/jump control path. It drives the instruction-memory address, decodes each fetched instruction, and issues one-hot strobes to the ALU, register file and data memory, waiting on a ready handshake for memory. It also supports conditional jumps on a latched carry flag and CALL/RET through a bounded hardware return stack.

## Interface
- ADDR_WIDTH, 5, program counter / instruction address width.
- INST_WIDTH, 8, instruction word width.
- OPCODE_WIDTH, 3, opcode field, located in inst[INST_WIDTH-1 -: OPCODE_WIDTH].
- STACK_DEPTH, 4, return-stack entries. Must be at least 1.
- Constraint: INST_WIDTH-OPCODE_WIDTH >= ADDR_WIDTH. The operand is the low ADDR_WIDTH bits of inst.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  in IDLE, begins execution at pc.
- inst  in  INST_WIDTH  instruction read combinationally from ROM at address pc.
- alu_cout  in  1  ALU carry, sampled only while alu_en=1.
- mem_ready  in  1  data-memory handshake completion.
- pc  out  ADDR_WIDTH  instruction address.
- mem_addr  out  ADDR_WIDTH  operand of the instruction being executed.
- alu_en  out  1  ALU operation strobe.
- reg_we  out  1  register-file write strobe.
- mem_re  out  1  data-memory read request.
- mem_we  out  1  data-memory write request.
- halted  out  1  sticky stop indicator.
- stack_err  out  1  sticky return-stack overflow/underflow.

## Operation
- Opcodes:
  - 000 ALU: alu_en=1 and reg_we=1 for one cycle; carry flag <= alu_cout.
  - 001 LOAD.
  - 010 STORE.
  - 011 JMP.
  - 100 JC: jump if carry flag = 1.
  - 101 CALL.
  - 110 RET.
  - 111 HLT.
- State IDLE:
  - start=1 -> FETCH; otherwise hold.
- State FETCH:
  - Latch inst into the internal IR.
  - Go to EXEC.
- State EXEC:
  - ALU: pc <= pc+1 -> FETCH.
  - JMP: pc <= operand -> FETCH.
  - JC: pc <= carry ? operand : pc+1 -> FETCH.
  - CALL: if the stack is full -> stack_err=1, go to HALT, pc unchanged. Otherwise push pc+1, pc <= operand -> FETCH.
  - RET: if the stack is empty -> stack_err=1, go to HALT, pc unchanged. Otherwise pc <= pop -> FETCH.
  - LOAD/STORE: assert mem_re or mem_we. If mem_ready=1 this cycle, complete it. Otherwise go to MEM.
  - HLT: go to HALT, pc unchanged.
- State MEM:
  - Hold mem_re or mem_we and mem_addr until mem_ready=1.
  - On the completing cycle: LOAD also pulses reg_we; pc <= pc+1 -> FETCH.
- State HALT:
  - halted=1, all strobes 0.
  - Only rst exits this state; start is ignored.
- pc arithmetic is modulo 2^ADDR_WIDTH, so all-ones + 1 wraps to 0. A pushed return address wraps the same way.
- The carry flag changes only on an ALU instruction. JC never modifies it.

## Timing
- All outputs are registered or decoded from registered state and IR. No output combinationally depends on inst, alu_cout or start.
- mem_ready does reach reg_we combinationally in EXEC/MEM; the bench accounts for this path.
- Reset values: pc=0, mem_addr=0, all strobes 0, halted=0, stack_err=0, carry=0, stack pointer=0, state IDLE.
- rst mid-operation (including MEM waits) takes priority. The next cycle shows the reset values and the pending request is dropped.
- Latency:
  - Non-memory instruction: 2 cycles (FETCH+EXEC).
  - Memory instruction: 2 + N cycles, where N is the number of EXEC/MEM cycles with mem_ready=0.
- The first FETCH occurs the cycle after start is sampled high in IDLE.
- Strobes are high only in EXEC/MEM, never in FETCH.
- mem_re and mem_we are never high together.
- mem_ready is ignored outside EXEC/MEM for memory instructions.
- halted rises the cycle after EXEC of HLT, or after EXEC of a faulting CALL/RET.

## Structure
- Shared package seq_pkg holds:
  - Opcode localparams.
  - FSM state enum: IDLE, FETCH, EXEC, MEM, HALT.
- Sub-module call_stack: a synchronous LIFO.
  - Parameters: width ADDR_WIDTH, depth STACK_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Push-when-full and pop-when-empty are ignored; the controller flags them.
- The controller holds the FSM, IR, pc, carry flag and output decode.

## Test plan
- Reset, start; ROM 0:ALU, 1:JMP 5, 5:HLT -> pc 0,1,5; alu_en one pulse; halted=1 on the 7th cycle after start; start afterwards is ignored.
- 0:ALU with alu_cout=1, 1:JC 10 -> pc=10. Rerun with alu_cout=0 -> pc=2.
- Four nested CALLs (0:CALL 8, 8:CALL 16, 16:CALL 20, 20:CALL 24) then 24:CALL 28 -> stack_err=1, halted=1, pc=24. In a separate run, four RETs return 21, 17, 9, 1.
- 0:LOAD 7 with mem_ready low for 3 cycles -> mem_re high 4 cycles, mem_addr=7, reg_we single pulse with mem_ready, then pc=1. 0:STORE 3 with mem_ready=1 immediately -> mem_we one cycle.
- 0:RET on an empty stack -> stack_err=1, halted=1, pc=0. rst during a MEM wait -> next cycle mem_re=0, pc=0, IDLE.
- pc=31 executing ALU -> pc=0 (wrap); CALL at 31 pushes return address 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared opcode encodings and FSM state type for the instruction sequencer.
package seq_pkg;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_JMP   = 3'b011;
    localparam logic [2:0] OP_JC    = 3'b100;
    localparam logic [2:0] OP_CALL  = 3'b101;
    localparam logic [2:0] OP_RET   = 3'b110;
    localparam logic [2:0] OP_HLT   = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_t;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/call_stack.sv
// Synchronous LIFO holding CALL return addresses; overflow and underflow
// requests are dropped here and reported by the controller.
module call_stack #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [2**IDXW];
    logic [SPW-1:0]   sp_q;
    logic [IDXW-1:0]  rd_idx_s;

    assign full     = (sp_q == SPW'(DEPTH));
    assign empty    = (sp_q == '0);
    assign rd_idx_s = sp_q[IDXW-1:0] - IDXW'(1);
    assign dout     = mem_q[rd_idx_s];

    // Stack pointer; push has priority, illegal requests leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    // Entry storage needs no reset: the pointer masks stale contents.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[IDXW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle fetch/execute sequencer: drives the ROM address, decodes the
// latched instruction into one-hot strobes and manages CALL/RET and carry.
module seq_controller
    import seq_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int INST_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int STACK_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  alu_cout,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  alu_en,
    output logic                  reg_we,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic                  halted,
    output logic                  stack_err
);

    state_t                  state_q;
    logic [INST_WIDTH-1:0]   ir_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic                    carry_q;
    logic                    halted_q;
    logic                    stack_err_q;

    logic [OPCODE_WIDTH-1:0] op_s;
    logic [ADDR_WIDTH-1:0]   operand_s;
    logic [ADDR_WIDTH-1:0]   pc_inc_s;
    logic [ADDR_WIDTH-1:0]   stk_dout_s;
    logic                    stk_full_s;
    logic                    stk_empty_s;
    logic                    push_s;
    logic                    pop_s;

    assign op_s      = ir_q[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign operand_s = ir_q[ADDR_WIDTH-1:0];
    assign pc_inc_s  = pc_q + ADDR_WIDTH'(1);
    assign push_s    = (state_q == EXEC) && (op_s == OP_CALL) && !stk_full_s;
    assign pop_s     = (state_q == EXEC) && (op_s == OP_RET) && !stk_empty_s;

    call_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (pc_inc_s),
        .dout  (stk_dout_s),
        .full  (stk_full_s),
        .empty (stk_empty_s)
    );

    // Sequencer FSM with pc, IR, carry and the sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            pc_q        <= '0;
            carry_q     <= 1'b0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    ir_q    <= inst;
                    state_q <= EXEC;
                end
                EXEC: begin
                    case (op_s)
                        OP_ALU: begin
                            carry_q <= alu_cout;
                            pc_q    <= pc_inc_s;
                            state_q <= FETCH;
                        end
                        OP_LOAD, OP_STORE: begin
                            if (mem_ready) begin
                                pc_q    <= pc_inc_s;
                                state_q <= FETCH;
                            end else begin
                                state_q <= MEM;
                            end
                        end
                        OP_JMP: begin
                            pc_q    <= operand_s;
                            state_q <= FETCH;
                        end
                        OP_JC: begin
                            pc_q    <= carry_q ? operand_s : pc_inc_s;
                            state_q <= FETCH;
                        end
                        OP_CALL: begin
                            if (stk_full_s) begin
                                stack_err_q <= 1'b1;
                                halted_q    <= 1'b1;
                                state_q     <= HALT;
                            end else begin
                                pc_q    <= operand_s;
                                state_q <= FETCH;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty_s) begin
                                stack_err_q <= 1'b1;
                                halted_q    <= 1'b1;
                                state_q     <= HALT;
                            end else begin
                                pc_q    <= stk_dout_s;
                                state_q <= FETCH;
                            end
                        end
                        default: begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        pc_q    <= pc_inc_s;
                        state_q <= FETCH;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode from registered state and IR; only mem_ready reaches reg_we.
    always_comb begin
        alu_en = 1'b0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        reg_we = 1'b0;
        if ((state_q == EXEC) || (state_q == MEM)) begin
            alu_en = (state_q == EXEC) && (op_s == OP_ALU);
            mem_re = is_mem_op(op_s) && (op_s == OP_LOAD);
            mem_we = is_mem_op(op_s) && (op_s == OP_STORE);
            reg_we = alu_en || (mem_re && mem_ready);
        end else begin
            alu_en = 1'b0;
        end
    end

    assign pc        = pc_q;
    assign mem_addr  = operand_s;
    assign halted    = halted_q;
    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: a behavioural ROM feeds inst from pc and
// each step compares outputs against hand-derived values.
module tb_seq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] inst;
    logic       alu_cout = 1'b0;
    logic       mem_ready = 1'b0;
    logic [4:0] pc;
    logic [4:0] mem_addr;
    logic       alu_en, reg_we, mem_re, mem_we, halted, stack_err;

    logic [7:0] rom [32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign inst = rom[pc];

    seq_controller dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inst      (inst),
        .alu_cout  (alu_cout),
        .mem_ready (mem_ready),
        .pc        (pc),
        .mem_addr  (mem_addr),
        .alu_en    (alu_en),
        .reg_we    (reg_we),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .halted    (halted),
        .stack_err (stack_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 32; i++) rom[i] = 8'hE0;
    endtask

    // Reset, then sample start in IDLE; returns in the first FETCH cycle.
    task automatic begin_run();
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset values
        rom_clear();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_pc", pc, 5'd0);
        chk("rst_addr", mem_addr, 5'd0);
        chk("rst_strobes", {alu_en, reg_we, mem_re, mem_we}, 4'b0000);
        chk("rst_flags", {halted, stack_err}, 2'b00);
        ticks(2);
        chk("idle_hold_pc", pc, 5'd0);

        // 0:ALU 1:JMP 5 5:HLT
        rom_clear();
        rom[0] = 8'b000_00000;
        rom[1] = 8'b011_00101;
        rom[5] = 8'b111_00000;
        begin_run();
        chk("t1_fetch_pc", pc, 5'd0);
        chk("t1_fetch_alu", alu_en, 1'b0);
        tick();
        chk("t1_exec_alu", {alu_en, reg_we}, 2'b11);
        tick();
        chk("t1_pc1", pc, 5'd1);
        chk("t1_alu_off", alu_en, 1'b0);
        tick();
        chk("t1_jmp_alu", alu_en, 1'b0);
        tick();
        chk("t1_pc5", pc, 5'd5);
        tick();
        chk("t1_halt_pre", halted, 1'b0);
        tick();
        chk("t1_halted", halted, 1'b1);
        chk("t1_halt_pc", pc, 5'd5);
        start = 1'b1;
        ticks(3);
        start = 1'b0;
        chk("t1_start_ign", {halted, pc}, {1'b1, 5'd5});
        chk("t1_halt_strb", {alu_en, reg_we, mem_re, mem_we}, 4'b0000);

        // JC taken / not taken
        rom_clear();
        rom[0] = 8'b000_00000;
        rom[1] = 8'b100_01010;
        alu_cout = 1'b1;
        begin_run();
        ticks(4);
        chk("jc_taken_pc", pc, 5'd10);
        alu_cout = 1'b0;
        begin_run();
        ticks(4);
        chk("jc_not_pc", pc, 5'd2);

        // Stack overflow on fifth nested CALL
        rom_clear();
        rom[0]  = 8'b101_01000;
        rom[8]  = 8'b101_10000;
        rom[16] = 8'b101_10100;
        rom[20] = 8'b101_11000;
        rom[24] = 8'b101_11100;
        begin_run();
        ticks(8);
        chk("call_pc24", pc, 5'd24);
        chk("call_noerr", {halted, stack_err}, 2'b00);
        ticks(2);
        chk("ovf_flags", {halted, stack_err}, 2'b11);
        chk("ovf_pc", pc, 5'd24);

        // Four CALLs then four RETs
        rom[24] = 8'b110_00000;
        rom[21] = 8'b110_00000;
        rom[17] = 8'b110_00000;
        rom[9]  = 8'b110_00000;
        rom[1]  = 8'b111_00000;
        begin_run();
        ticks(10);
        chk("ret_21", pc, 5'd21);
        ticks(2);
        chk("ret_17", pc, 5'd17);
        ticks(2);
        chk("ret_9", pc, 5'd9);
        ticks(2);
        chk("ret_1", pc, 5'd1);
        ticks(2);
        chk("ret_end", {halted, stack_err}, 2'b10);

        // LOAD 7 with three wait cycles
        rom_clear();
        rom[0] = 8'b001_00111;
        mem_ready = 1'b0;
        begin_run();
        chk("ld_fetch_re", mem_re, 1'b0);
        tick();
        chk("ld_exec", {mem_re, mem_we, reg_we}, 3'b100);
        chk("ld_addr", mem_addr, 5'd7);
        tick();
        chk("ld_wait1", {mem_re, reg_we}, 2'b10);
        tick();
        chk("ld_wait2", {mem_re, reg_we, mem_addr}, {2'b10, 5'd7});
        chk("ld_pc_hold", pc, 5'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("ld_done", {mem_re, reg_we}, 2'b11);
        tick();
        mem_ready = 1'b0;
        chk("ld_after", {mem_re, reg_we, pc}, {2'b00, 5'd1});

        // STORE 3 with immediate ready
        rom_clear();
        rom[0] = 8'b010_00011;
        mem_ready = 1'b1;
        begin_run();
        chk("st_fetch", {mem_we, mem_re}, 2'b00);
        tick();
        chk("st_exec", {mem_we, mem_re, reg_we, mem_addr}, {3'b100, 5'd3});
        tick();
        chk("st_after", {mem_we, pc}, {1'b0, 5'd1});
        mem_ready = 1'b0;

        // RET on empty stack
        rom_clear();
        rom[0] = 8'b110_00000;
        begin_run();
        ticks(2);
        chk("uf_flags", {halted, stack_err, pc}, {2'b11, 5'd0});

        // rst during MEM wait
        rom_clear();
        rom[0] = 8'b001_00111;
        begin_run();
        ticks(2);
        chk("rm_inmem", mem_re, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_after", {mem_re, reg_we, pc, halted}, {2'b00, 5'd0, 1'b0});
        ticks(2);
        chk("rm_idle", {mem_re, alu_en, pc}, {2'b00, 5'd0});

        // pc wrap on ALU at 31
        rom_clear();
        rom[0]  = 8'b011_11111;
        rom[31] = 8'b000_00000;
        begin_run();
        ticks(2);
        chk("wrap_pc31", pc, 5'd31);
        ticks(2);
        chk("wrap_pc0", pc, 5'd0);

        // CALL at 31 pushes 0
        rom[31] = 8'b101_00100;
        rom[4]  = 8'b110_00000;
        begin_run();
        ticks(4);
        chk("cw_pc4", pc, 5'd4);
        ticks(2);
        chk("cw_ret0", {pc, stack_err}, {5'd0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
